mymul_seq: RTL and testbench
============================

# mymul_seq

Parametrised sequential shift-add multiplier, successor to the 2x2 combinational multiplier. Multiplies two W-bit operands, unsigned or two's-complement (selected per operation), over W clock cycles with a start/busy/done handshake. Sits in the datapath lab designs wherever a W×W product is needed and single-cycle combinational area is not acceptable.

## Interface
- W, default 4, operand width (W ≥ 2); product width is 2W
- clk  input  1  rising-edge clock, the block's only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sgn  input  1  0 = unsigned operands, 1 = two's-complement; latched with operands
- a  input  W  multiplicand, latched on accepted start
- b  input  W  multiplier, latched on accepted start
- p  output  2W  product; holds last result until the next result is written
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when p holds a new result

## Operation
- States: IDLE, RUN. Iteration counter cnt, width clog2(W+1).
- IDLE: on an edge with start=1: latch sgn; latch |a|, |b| (when sgn=1, magnitude of the two's-complement value; when sgn=0, raw value); latch neg = sgn & (a[W-1] ^ b[W-1]); clear accumulator; cnt←0; state←RUN. Otherwise hold.
- Magnitude of −2^(W−1) is 2^(W−1), which fits in W unsigned bits; no overflow possible.
- RUN, each edge: if multiplier LSB=1, add multiplicand (shifted by cnt) into the 2W-bit accumulator; shift multiplier right; cnt←cnt+1.
- On the RUN edge where cnt reaches W: p←neg ? −acc : acc (2W-bit two's complement); done←1; state←IDLE.
- start asserted while in RUN: ignored, no effect on the operation in progress, not queued.
- a, b, sgn changing during RUN: no effect.
- Unsigned result range 0..(2^W−1)²; signed range −2^(2W−2)+2^(W−1)..2^(2W−2); both fit 2W bits exactly.
- rst=1 on any edge: state←IDLE, cnt←0, accumulator←0, p←0, busy←0, done←0; an in-flight operation is discarded, no done pulse.

## Timing
- Reset values: p=0, busy=0, done=0.
- Start accepted at edge E0. busy=1 in the cycles after E0 up to edge E0+W; busy=0 after E0+W.
- p updated and done=1 at edge E0+W; done returns to 0 at edge E0+W+1. Latency W cycles start-to-done.
- busy and done are never high in the same cycle.
- start=1 in the cycle where done=1: accepted at the next edge (state already IDLE); back-to-back operations every W+1 cycles... specifically, new E0 = previous E0+W+1.
- start held high continuously: one operation per W+1 cycles.
- p is stable from the done edge until the done edge of the next operation; p is not altered by start.

## Test plan
- W=4, sgn=0, a=3, b=2, start for one cycle → done pulse exactly 4 edges later, p=8'h06, busy high for 4 cycles.
- W=4, sgn=0, a=15, b=15 → p=8'hE1 (225); then a=0, b=9 → p=8'h00.
- W=4, sgn=1: a=4'hE (−2), b=3 → p=8'hFA (−6); a=4'h8 (−8), b=4'h8 (−8) → p=8'h40 (64); a=4'h8, b=1 → p=8'hF8 (−8).
- W=4: start pulsed again 2 cycles after acceptance with different operands → ignored; p equals the first product, one done pulse only; start in done cycle → second op accepted, done 5 edges after first done.
- W=4: rst asserted 2 cycles into RUN → next cycle busy=0, done=0, p=0; no done pulse follows; a fresh start then completes normally.
- W=2 instance, sgn=0, exhaustive: all 16 (a,b) pairs incl. 2×2→4, 1×3→3, 2×3→6, 2×1→2 → p=a·b each, done 2 edges after start; W=8 random sweep (sgn both values) against a reference product.

Source files
------------

// File: rtl/mymul_seq_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
// The master issues start with operands; the slave returns p with busy/done.
interface mymul_seq_if #(
  parameter int W = 4
);
  logic           start;
  logic           sgn;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] p;
  logic           busy;
  logic           done;

  modport master (output start, sgn, a, b, input p, busy, done);
  modport slave  (input start, sgn, a, b, output p, busy, done);
endinterface

// File: rtl/mymul_seq.sv
// Sequential W x W shift-add multiplier, unsigned or two's-complement per operation.
// Operates on magnitudes for W cycles, then applies the sign when writing p.
module mymul_seq #(
  parameter int W = 4
) (
  input logic         clk,
  input logic         rst,
  mymul_seq_if.slave  bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2*W-1:0] acc_reg;
  logic [2*W-1:0] mcand_reg;
  logic [W-1:0]   mplier_reg;
  logic           neg_reg;
  logic [2*W-1:0] p_reg;
  logic           busy_reg;
  logic           done_reg;

  logic [W-1:0]   a_neg;
  logic [W-1:0]   b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [2*W-1:0] addend;
  logic [2*W-1:0] acc_next;
  logic [2*W-1:0] acc_neg;
  logic [CW-1:0]  cnt_next;

  // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude.
  assign a_neg = -bus.a;
  assign b_neg = -bus.b;
  assign a_mag = (bus.sgn && bus.a[W-1]) ? a_neg : bus.a;
  assign b_mag = (bus.sgn && bus.b[W-1]) ? b_neg : bus.b;

  genvar gi;
  generate
    for (gi = 0; gi < 2 * W; gi++) begin : g_pp
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign acc_next = acc_reg + addend;
  assign acc_neg  = -acc_next;
  assign cnt_next = cnt_reg + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      neg_reg    <= 1'b0;
      p_reg      <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            mcand_reg  <= {{W{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            neg_reg    <= bus.sgn & (bus.a[W-1] ^ bus.b[W-1]);
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_next;
          // Final iteration: the sum including this step's partial product is the result.
          if (cnt_next == CW'(W)) begin
            p_reg     <= neg_reg ? acc_neg : acc_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.p    = p_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
endmodule

// File: tb/tb_mymul_seq.sv
// Directed bench for mymul_seq at W=4, exhaustive W=2 and a W=8 sweep,
// checking handshake timing and products against bench-computed values.
module tb_mymul_seq;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_checks;

  mymul_seq_if #(.W(2)) b2 ();
  mymul_seq_if #(.W(4)) b4 ();
  mymul_seq_if #(.W(8)) b8 ();

  mymul_seq #(.W(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  mymul_seq #(.W(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  mymul_seq #(.W(8)) u8 (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One W=4 operation: latency, busy duration, product, done pulse width.
  task automatic op4(input string tag, input logic s, input logic [3:0] x, input logic [3:0] y,
                     input logic [7:0] exp);
    int lat;
    int busy_cnt;
    b4.start = 1'b1; b4.sgn = s; b4.a = x; b4.b = y;
    tick;
    b4.start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!b4.done && lat < 20) begin
      if (b4.busy) busy_cnt++;
      tick;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'd4);
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd4);
    check({tag, ".busy_at_done"}, 64'(b4.busy), 64'd0);
    check({tag, ".p"}, 64'(b4.p), 64'(exp));
    tick;
    check({tag, ".done_drop"}, 64'(b4.done), 64'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [1:0] x2, y2;
    logic [7:0] x8, y8;
    logic       s8;
    int         ea, eb;
    logic [15:0] e8;

    n_pass = 0; n_checks = 0;
    rst = 1'b1;
    b2.start = 1'b0; b2.sgn = 1'b0; b2.a = '0; b2.b = '0;
    b4.start = 1'b0; b4.sgn = 1'b0; b4.a = '0; b4.b = '0;
    b8.start = 1'b0; b8.sgn = 1'b0; b8.a = '0; b8.b = '0;
    repeat (3) tick;
    check("rst.p", 64'(b4.p), 64'd0);
    check("rst.busy", 64'(b4.busy), 64'd0);
    check("rst.done", 64'(b4.done), 64'd0);
    rst = 1'b0;
    tick;

    op4("u3x2", 1'b0, 4'd3, 4'd2, 8'h06);
    op4("u15x15", 1'b0, 4'd15, 4'd15, 8'hE1);
    op4("u0x9", 1'b0, 4'd0, 4'd9, 8'h00);
    op4("s-2x3", 1'b1, 4'hE, 4'd3, 8'hFA);
    op4("s-8x-8", 1'b1, 4'h8, 4'h8, 8'h40);
    op4("s-8x1", 1'b1, 4'h8, 4'd1, 8'hF8);
    op4("u8x1", 1'b0, 4'h8, 4'd1, 8'h08);

    // start during RUN is ignored; start in the done cycle is accepted next edge
    b4.start = 1'b1; b4.sgn = 1'b0; b4.a = 4'd3; b4.b = 4'd5;
    tick;
    b4.start = 1'b0;
    tick; tick;
    b4.start = 1'b1; b4.a = 4'd7; b4.b = 4'd7; b4.sgn = 1'b1;
    tick;
    b4.start = 1'b0; b4.a = 4'd1; b4.b = 4'd1;
    tick;
    check("ign.done", 64'(b4.done), 64'd1);
    check("ign.p", 64'(b4.p), 64'h0F);
    b4.start = 1'b1; b4.sgn = 1'b0; b4.a = 4'd2; b4.b = 4'd6;
    tick;
    b4.start = 1'b0;
    lat = 1;
    while (!b4.done && lat < 20) begin
      tick;
      lat++;
    end
    check("b2b.lat", 64'(lat), 64'd5);
    check("b2b.p", 64'(b4.p), 64'h0C);
    pulses = 0;
    repeat (8) begin
      tick;
      if (b4.done) pulses++;
    end
    check("b2b.extra_done", 64'(pulses), 64'd0);
    check("b2b.p_hold", 64'(b4.p), 64'h0C);

    // reset mid-operation discards it
    b4.start = 1'b1; b4.a = 4'd5; b4.b = 4'd3;
    tick;
    b4.start = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst.busy", 64'(b4.busy), 64'd0);
    check("midrst.done", 64'(b4.done), 64'd0);
    check("midrst.p", 64'(b4.p), 64'd0);
    pulses = 0;
    repeat (8) begin
      tick;
      if (b4.done) pulses++;
    end
    check("midrst.no_done", 64'(pulses), 64'd0);
    op4("post_rst", 1'b0, 4'd6, 4'd7, 8'h2A);

    // W=2 exhaustive unsigned
    for (int i = 0; i < 16; i++) begin
      x2 = 2'(i >> 2); y2 = 2'(i);
      b2.start = 1'b1; b2.sgn = 1'b0; b2.a = x2; b2.b = y2;
      tick;
      b2.start = 1'b0;
      lat = 0;
      while (!b2.done && lat < 20) begin
        tick;
        lat++;
      end
      check($sformatf("w2.%0dx%0d.lat", x2, y2), 64'(lat), 64'd2);
      check($sformatf("w2.%0dx%0d.p", x2, y2), 64'(b2.p), 64'(x2) * 64'(y2));
      tick;
    end

    // W=8: two corners then a random sweep, both signedness modes
    for (int i = 0; i < 24; i++) begin
      s8 = i[0];
      if (i == 0) begin x8 = 8'hFF; y8 = 8'hFF; end
      else if (i == 1) begin x8 = 8'h80; y8 = 8'h80; end
      else begin x8 = 8'($urandom); y8 = 8'($urandom); end
      ea = s8 ? int'($signed(x8)) : int'(x8);
      eb = s8 ? int'($signed(y8)) : int'(y8);
      e8 = 16'(ea * eb);
      b8.start = 1'b1; b8.sgn = s8; b8.a = x8; b8.b = y8;
      tick;
      b8.start = 1'b0;
      lat = 0;
      while (!b8.done && lat < 40) begin
        tick;
        lat++;
      end
      check($sformatf("w8.%0d.lat", i), 64'(lat), 64'd8);
      check($sformatf("w8.s%0d.%0hx%0h.p", s8, x8, y8), 64'(b8.p), 64'(e8));
      tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
